// File: rtl/mtr_spd_sched.sv
// mtr_spd_sched: speed-command sequencer in front of mtr_drv.
// Slew-limits left/right speed targets into lft_spd/rght_spd and owns the
// overcurrent recovery policy (force neutral, cool down, re-ramp, and latch a
// fault after MAX_RETRY shutdowns).
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   en                  - motor enable; 0 ramps both channels to neutral
//   lft_tgt, rght_tgt   - target speeds, offset binary (12'h800 = neutral)
//   OVR_I_shtdwn        - overcurrent shutdown level from mtr_drv
//   clr_fault           - single-cycle fault clear request (honoured with en=0)
//   lft_spd, rght_spd   - registered speed commands to mtr_drv
//   at_tgt              - both commands equal their effective targets (RUN only)
//   fault               - retries exhausted, latched until cleared
//   retry_cnt           - shutdowns counted since the last IDLE
module mtr_spd_sched #(
  parameter logic [11:0] STEP      = 12'h010,
  parameter int unsigned UPD_DIV   = 1024,
  parameter int unsigned COOL_CYC  = 1_000_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] lft_tgt,
  input  logic [11:0] rght_tgt,
  input  logic        OVR_I_shtdwn,
  input  logic        clr_fault,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        at_tgt,
  output logic        fault,
  output logic [2:0]  retry_cnt
);

  localparam int unsigned SPD_W  = 12;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DIV_W  = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
  localparam int unsigned COOL_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;

  localparam logic [SPD_W-1:0]  NEUTRAL   = 12'h800;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(UPD_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOL_CYC - 1);
  localparam logic [CNT_W-1:0]  RETRY_LIM = CNT_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    COOL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [COOL_W-1:0]  cool_q, cool_n;
  logic [SPD_W-1:0]   lft_n, rght_n;
  logic [SPD_W-1:0]   eff_lft, eff_rght;
  logic [CNT_W-1:0]   retry_n;
  logic               at_tgt_n;
  logic               fault_n;

  // Move spd toward tgt by at most STEP; comparing first avoids wrap/overshoot.
  function automatic logic [SPD_W-1:0] slew(input logic [SPD_W-1:0] spd,
                                             input logic [SPD_W-1:0] tgt);
    logic [SPD_W-1:0] diff;
    diff = '0;
    if (tgt > spd) begin
      diff = tgt - spd;
      slew = (diff > STEP) ? spd + STEP : tgt;
    end else begin
      diff = spd - tgt;
      slew = (diff > STEP) ? spd - STEP : tgt;
    end
  endfunction

  // Disabled motor ramps toward neutral.
  assign eff_lft  = en ? lft_tgt  : NEUTRAL;
  assign eff_rght = en ? rght_tgt : NEUTRAL;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cool_q    <= '0;
      lft_spd   <= NEUTRAL;
      rght_spd  <= NEUTRAL;
      at_tgt    <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state_q   <= state_n;
      div_q     <= div_n;
      cool_q    <= cool_n;
      lft_spd   <= lft_n;
      rght_spd  <= rght_n;
      at_tgt    <= at_tgt_n;
      fault     <= fault_n;
      retry_cnt <= retry_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_q;
    div_n    = div_q;
    cool_n   = cool_q;
    lft_n    = lft_spd;
    rght_n   = rght_spd;
    retry_n  = retry_cnt;
    at_tgt_n = 1'b0;

    unique case (state_q)
      IDLE: begin
        lft_n   = NEUTRAL;
        rght_n  = NEUTRAL;
        retry_n = '0;
        if (en) begin
          state_n = RUN;
          div_n   = '0;
        end
      end

      RUN: begin
        if (OVR_I_shtdwn) begin
          // Overcurrent outranks everything else in RUN.
          lft_n   = NEUTRAL;
          rght_n  = NEUTRAL;
          retry_n = retry_cnt + CNT_W'(1);
          if (retry_n < RETRY_LIM) begin
            state_n = COOL;
            cool_n  = '0;
          end else begin
            state_n = FAULT;
          end
        end else if (!en && (lft_spd == NEUTRAL) && (rght_spd == NEUTRAL)) begin
          state_n = IDLE;
          retry_n = '0;
        end else begin
          at_tgt_n = (lft_spd == eff_lft) && (rght_spd == eff_rght);
          if (div_q == DIV_LAST) begin
            div_n  = '0;
            lft_n  = slew(lft_spd, eff_lft);
            rght_n = slew(rght_spd, eff_rght);
          end else begin
            div_n = div_q + DIV_W'(1);
          end
        end
      end

      COOL: begin
        lft_n  = NEUTRAL;
        rght_n = NEUTRAL;
        if (cool_q == COOL_LAST) begin
          state_n = RUN;
          div_n   = '0;
        end else begin
          cool_n = cool_q + COOL_W'(1);
        end
      end

      FAULT: begin
        lft_n  = NEUTRAL;
        rght_n = NEUTRAL;
        if (clr_fault && !en) begin
          state_n = IDLE;
          retry_n = '0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    fault_n = (state_n == FAULT);
  end

endmodule

// File: tb/tb_mtr_spd_sched.sv
// Testbench for mtr_spd_sched: directed scenarios plus randomized stimulus,
// checked against a behavioural model that counts clocks since RUN entry and
// cooldown clocks remaining.
module tb_mtr_spd_sched;

  localparam logic [11:0] STEP = 12'h010;
  localparam int STEP_I = 16;
  localparam int UPD    = 4;
  localparam int COOL   = 16;
  localparam int MAXR   = 2;

  localparam int MD_IDLE  = 0;
  localparam int MD_RUN   = 1;
  localparam int MD_COOL  = 2;
  localparam int MD_FAULT = 3;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] lft_tgt;
  logic [11:0] rght_tgt;
  logic        ovr;
  logic        clr;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        at_tgt;
  logic        fault;
  logic [2:0]  retry_cnt;

  logic [28:0] dvec;
  assign dvec = {lft_spd, rght_spd, at_tgt, fault, retry_cnt};

  int checks = 0;
  int errors = 0;

  int m_mode, m_l, m_r, m_retry, m_run_clk, m_cool_left;
  bit m_at, m_fault;

  mtr_spd_sched #(
    .STEP      (STEP),
    .UPD_DIV   (UPD),
    .COOL_CYC  (COOL),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .lft_tgt      (lft_tgt),
    .rght_tgt     (rght_tgt),
    .OVR_I_shtdwn (ovr),
    .clr_fault    (clr),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .at_tgt       (at_tgt),
    .fault        (fault),
    .retry_cnt    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int approach(input int s, input int t);
    if (t > s) return (t - s > STEP_I) ? s + STEP_I : t;
    else       return (s - t > STEP_I) ? s - STEP_I : t;
  endfunction

  function automatic logic [28:0] mvec();
    return {12'(m_l), 12'(m_r), m_at, m_fault, 3'(m_retry)};
  endfunction

  task automatic model_reset();
    m_mode = MD_IDLE; m_l = 2048; m_r = 2048; m_at = 0; m_fault = 0;
    m_retry = 0; m_run_clk = 0; m_cool_left = 0;
  endtask

  // One rising edge of the reference behaviour, using current inputs.
  task automatic model_edge();
    int el, er;
    bit at_new;
    el = en ? int'(lft_tgt)  : 2048;
    er = en ? int'(rght_tgt) : 2048;
    case (m_mode)
      MD_IDLE: begin
        m_l = 2048; m_r = 2048; m_at = 0; m_retry = 0;
        if (en) begin m_mode = MD_RUN; m_run_clk = 0; end
      end
      MD_RUN: begin
        at_new = (m_l == el) && (m_r == er);
        if (ovr) begin
          m_retry++; m_l = 2048; m_r = 2048; m_at = 0;
          if (m_retry < MAXR) begin m_mode = MD_COOL; m_cool_left = COOL; end
          else begin m_mode = MD_FAULT; m_fault = 1; end
        end else if (!en && m_l == 2048 && m_r == 2048) begin
          m_mode = MD_IDLE; m_retry = 0; m_at = 0;
        end else begin
          m_at = at_new;
          m_run_clk++;
          if (m_run_clk % UPD == 0) begin
            m_l = approach(m_l, el);
            m_r = approach(m_r, er);
          end
        end
      end
      MD_COOL: begin
        m_at = 0;
        m_cool_left--;
        if (m_cool_left == 0) begin m_mode = MD_RUN; m_run_clk = 0; end
      end
      default: begin
        if (clr && !en) begin m_mode = MD_IDLE; m_retry = 0; m_fault = 0; end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget && m_mode != MD_IDLE; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; lft_tgt = 12'h800; rght_tgt = 12'h800;
    ovr = 1'b0; clr = 1'b0;
    model_reset();
    #12;
    checks++;
    if (dvec !== {12'h800, 12'h800, 1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL reset_values got=%h want=%h", dvec, {12'h800, 12'h800, 5'd0});
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++;
    if (dvec !== mvec()) begin errors++; $display("FAIL reset_idle got=%h want=%h", dvec, mvec()); end
  endtask

  task automatic test_ramp_up();
    en = 1'b1; lft_tgt = 12'h840; rght_tgt = 12'h7C0;
    step();
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < UPD; j++) begin
        step();
        checks++;
        if (dvec !== mvec()) begin errors++; $display("FAIL ramp_model t=%0t got=%h want=%h", $time, dvec, mvec()); end
      end
      checks++;
      if (lft_spd !== 12'(2048 + 16 * k) || rght_spd !== 12'(2048 - 16 * k)) begin
        errors++; $display("FAIL ramp_step k=%0d got=%h/%h want=%h/%h", k, lft_spd, rght_spd,
                           12'(2048 + 16 * k), 12'(2048 - 16 * k));
      end
    end
    step();
    checks++;
    if (at_tgt !== 1'b1) begin errors++; $display("FAIL ramp_at_tgt got=%b want=1", at_tgt); end
    en = 1'b0;
    run_until_idle(100);
    step();
    checks++;
    if (m_mode != MD_IDLE || dvec !== {12'h800, 12'h800, 5'd0}) begin
      errors++; $display("FAIL ramp_to_idle got=%h want=%h", dvec, {12'h800, 12'h800, 5'd0});
    end
  endtask

  task automatic test_partial();
    en = 1'b1; lft_tgt = 12'h805; rght_tgt = 12'h800;
    step();
    repeat (UPD) step();
    checks++;
    if (lft_spd !== 12'h805 || rght_spd !== 12'h800) begin
      errors++; $display("FAIL partial_step got=%h/%h want=805/800", lft_spd, rght_spd);
    end
    lft_tgt = 12'hFF8; rght_tgt = 12'h005;
    for (int i = 0; i < 700 && !(m_l == 12'hFF8 && m_r == 5); i++) begin
      step();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL partial_model t=%0t got=%h want=%h", $time, dvec, mvec()); end
    end
    checks++;
    if (lft_spd !== 12'hFF8 || rght_spd !== 12'h005) begin
      errors++; $display("FAIL partial_far got=%h/%h want=ff8/005", lft_spd, rght_spd);
    end
    lft_tgt = 12'hFFF; rght_tgt = 12'h000;
    repeat (UPD) step();
    checks++;
    if (lft_spd !== 12'hFFF || rght_spd !== 12'h000) begin
      errors++; $display("FAIL partial_nowrap got=%h/%h want=fff/000", lft_spd, rght_spd);
    end
    step();
    checks++;
    if (at_tgt !== 1'b1) begin errors++; $display("FAIL partial_at_tgt got=%b want=1", at_tgt); end
    en = 1'b0;
    run_until_idle(800);
    checks++;
    if (m_mode != MD_IDLE || dvec !== mvec()) begin
      errors++; $display("FAIL partial_idle got=%h want=%h", dvec, mvec());
    end
  endtask

  task automatic test_overcurrent();
    en = 1'b1; lft_tgt = 12'h840; rght_tgt = 12'h7C0;
    step();
    repeat (2 * UPD) step();
    checks++;
    if (lft_spd !== 12'h820) begin errors++; $display("FAIL ovr_pre got=%h want=820", lft_spd); end
    ovr = 1'b1;
    step();
    ovr = 1'b0;
    checks++;
    if (dvec !== {12'h800, 12'h800, 1'b0, 1'b0, 3'd1}) begin
      errors++; $display("FAIL ovr_neutral got=%h want=%h", dvec, {12'h800, 12'h800, 5'd1});
    end
    for (int i = 1; i <= COOL + UPD; i++) begin
      step();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL ovr_model i=%0d got=%h want=%h", i, dvec, mvec()); end
      if (i == COOL + UPD - 1) begin
        checks++;
        if (lft_spd !== 12'h800) begin errors++; $display("FAIL ovr_cool_hold got=%h want=800", lft_spd); end
      end
    end
    checks++;
    if (lft_spd !== 12'h810 || rght_spd !== 12'h7F0 || retry_cnt !== 3'd1) begin
      errors++; $display("FAIL ovr_reramp got=%h/%h r=%0d want=810/7f0 r=1", lft_spd, rght_spd, retry_cnt);
    end
  endtask

  task automatic test_retry_exhaust();
    ovr = 1'b1;
    step();
    ovr = 1'b0;
    checks++;
    if (dvec !== {12'h800, 12'h800, 1'b0, 1'b1, 3'd2}) begin
      errors++; $display("FAIL fault_entry got=%h want=%h", dvec, {12'h800, 12'h800, 1'b0, 1'b1, 3'd2});
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (3) step();
    checks++;
    if (fault !== 1'b1 || retry_cnt !== 3'd2 || dvec !== mvec()) begin
      errors++; $display("FAIL fault_clr_en_ignored got=%h want=%h", dvec, mvec());
    end
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (dvec !== {12'h800, 12'h800, 5'd0}) begin
      errors++; $display("FAIL fault_clear got=%h want=%h", dvec, {12'h800, 12'h800, 5'd0});
    end
    en = 1'b1; lft_tgt = 12'h800; rght_tgt = 12'h800;
    step();
    en = 1'b0;
    step();
    checks++;
    if (dvec !== mvec()) begin errors++; $display("FAIL fault_post got=%h want=%h", dvec, mvec()); end
  endtask

  task automatic test_en_drop();
    logic [11:0] prev, exp_v;
    en = 1'b1; lft_tgt = 12'h840; rght_tgt = 12'h840;
    step();
    repeat (4 * UPD + 1) step();
    checks++;
    if (dvec !== {12'h840, 12'h840, 1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL drop_top got=%h want=%h", dvec, {12'h840, 12'h840, 1'b1, 4'd0});
    end
    en = 1'b0;
    exp_v = 12'h830;
    for (int i = 0; i < 40 && m_mode != MD_IDLE; i++) begin
      prev = lft_spd;
      step();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL drop_model t=%0t got=%h want=%h", $time, dvec, mvec()); end
      if (lft_spd !== prev) begin
        checks++;
        if (lft_spd !== exp_v) begin errors++; $display("FAIL drop_seq got=%h want=%h", lft_spd, exp_v); end
        exp_v = exp_v - STEP;
      end
    end
    checks++;
    if (exp_v !== 12'h7F0 || m_mode != MD_IDLE || lft_spd !== 12'h800) begin
      errors++; $display("FAIL drop_idle got=%h next=%h want=800 next=7f0", lft_spd, exp_v);
    end
    // Overcurrent in the same cycle as the enable drop wins.
    en = 1'b1;
    step();
    repeat (2 * UPD) step();
    en = 1'b0; ovr = 1'b1;
    step();
    ovr = 1'b0;
    repeat (10) step();
    checks++;
    if (dvec !== {12'h800, 12'h800, 1'b0, 1'b0, 3'd1}) begin
      errors++; $display("FAIL drop_ovr_cool got=%h want=%h", dvec, {12'h800, 12'h800, 5'd1});
    end
    repeat (COOL - 10 + 1) step();
    checks++;
    if (m_mode != MD_IDLE || dvec !== mvec()) begin
      errors++; $display("FAIL drop_ovr_idle got=%h want=%h", dvec, mvec());
    end
  endtask

  task automatic test_reset_mid_ramp();
    en = 1'b1; lft_tgt = 12'h840; rght_tgt = 12'h7C0;
    step();
    repeat (3 * UPD) step();
    checks++;
    if (lft_spd !== 12'h830 || rght_spd !== 12'h7D0) begin
      errors++; $display("FAIL rst_pre got=%h/%h want=830/7d0", lft_spd, rght_spd);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dvec !== {12'h800, 12'h800, 5'd0}) begin
      errors++; $display("FAIL rst_async got=%h want=%h", dvec, {12'h800, 12'h800, 5'd0});
    end
    model_reset();
    en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if (dvec !== mvec()) begin errors++; $display("FAIL rst_idle got=%h want=%h", dvec, mvec()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          lft_tgt = 12'($urandom); rght_tgt = 12'($urandom);
        end else begin
          lft_tgt  = 12'(12'h780 + $urandom_range(0, 255));
          rght_tgt = 12'(12'h780 + $urandom_range(0, 255));
        end
      end
      ovr = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 9) == 0);
      step();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL random i=%0d got=%h want=%h", i, dvec, mvec()); end
    end
    ovr = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_partial();
    test_overcurrent();
    test_retry_exhaust();
    test_en_drop();
    test_reset_mid_ramp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtr_spd_sched.md
# mtr_spd_sched

Speed-command sequencer sitting directly in front of `mtr_drv`. It slew-limits the left/right speed targets from the upstream controller into the `lft_spd`/`rght_spd` commands that `mtr_drv` consumes. It also owns the overcurrent recovery policy: on `OVR_I_shtdwn` it forces neutral, waits a cooldown, then re-ramps. After `MAX_RETRY` shutdowns it latches a fault.

## Interface
- `STEP`, 12'h010: maximum change per channel per update tick.
- `UPD_DIV`, 1024: clocks per update tick (≥2).
- `COOL_CYC`, 1_000_000: cooldown length in clocks (≥1).
- `MAX_RETRY`, 3: overcurrent shutdowns tolerated before fault (1..7).

- `clk`  in  1: system clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: motor enable; 0 requests a ramp to neutral.
- `lft_tgt`  in  12: left target speed, offset binary, 12'h800 = neutral.
- `rght_tgt`  in  12: right target speed, same encoding.
- `OVR_I_shtdwn`  in  1: overcurrent shutdown level from `mtr_drv`.
- `clr_fault`  in  1: single-cycle fault clear request.
- `lft_spd`  out  12: registered left command to `mtr_drv`.
- `rght_spd`  out  12: registered right command to `mtr_drv`.
- `at_tgt`  out  1: both outputs equal their effective targets (RUN only).
- `fault`  out  1: retries exhausted; latched.
- `retry_cnt`  out  3: shutdowns counted since last IDLE.

## Operation
- States: IDLE, RUN, COOL, FAULT. Reset state: IDLE.
- Effective target per channel: `*_tgt` when `en`=1, 12'h800 when `en`=0.
- IDLE
  - Outputs are 12'h800.
  - `retry_cnt` is 0.
  - `en`=1 → RUN, with the tick divider cleared.
- RUN
  - The tick divider counts 0..UPD_DIV-1; tick fires when the count reaches UPD_DIV-1.
  - On tick, each channel moves toward its effective target by min(STEP, |tgt−spd|).
  - Comparison is 12-bit unsigned. No overshoot and no wrap: 12'hFF8 with tgt 12'hFFF steps to 12'hFFF; 12'h005 with tgt 0 steps to 0.
  - `en`=0 and both outputs at 12'h800 → IDLE.
- Overcurrent (sampled only in RUN)
  - `OVR_I_shtdwn`=1 → both outputs 12'h800 on the next edge, and `retry_cnt`+1.
  - If the new count < MAX_RETRY → COOL, else → FAULT.
- COOL
  - Outputs are held at 12'h800.
  - A counter runs for COOL_CYC clocks, then → RUN (divider cleared, ramp restarts from neutral).
  - `OVR_I_shtdwn` and `en` are ignored during COOL.
- FAULT
  - Outputs are 12'h800 and `fault`=1.
  - `clr_fault`=1 with `en`=0 → IDLE (clears `fault` and `retry_cnt`).
  - `clr_fault` with `en`=1 is ignored.
- Priority within one cycle: async reset > overcurrent > `en` fall > tick.
- Target changes mid-ramp take effect at the next tick; no restart of the divider.

## Timing
- Reset values: `lft_spd`=`rght_spd`=12'h800, `at_tgt`=0, `fault`=0, `retry_cnt`=0.
- First step occurs UPD_DIV clocks after the RUN entry edge; subsequent steps every UPD_DIV clocks.
- `at_tgt` is registered. It is valid the cycle after the outputs reach the targets, and 0 outside RUN.
- Shutdown-to-neutral latency: 1 clock from the edge sampling `OVR_I_shtdwn`=1.
- COOL→RUN occurs exactly COOL_CYC clocks after COOL entry.
- Fault clear: IDLE on the edge after `clr_fault`.
- Async reset mid-operation: outputs return to reset values immediately, without waiting for a clock.

## Test plan
Bench parameters: STEP=12'h010, UPD_DIV=4, COOL_CYC=16, MAX_RETRY=2.
- Ramp up: `en`=1, `lft_tgt`=12'h840, `rght_tgt`=12'h7C0.
  - Outputs step 12'h810/12'h7F0 on each 4th clock.
  - Outputs reach 12'h840/12'h7C0 after 4 ticks (16 clocks); `at_tgt`=1 the cycle after.
- Partial step: from 12'h800 with `lft_tgt`=12'h805, one tick → `lft_spd`=12'h805 exactly.
  - `lft_tgt`=12'hFFF from 12'hFF8 → 12'hFFF, no wrap.
- Overcurrent: pulse `OVR_I_shtdwn` mid-ramp at `lft_spd`=12'h820.
  - Next clock both outputs are 12'h800 and `retry_cnt`=1.
  - 16 clocks later RUN resumes; the ramp restarts from 12'h800.
- Retry exhaustion: second shutdown → FAULT, `fault`=1, outputs 12'h800.
  - `clr_fault` with `en`=1 is ignored.
  - `en`=0 plus `clr_fault` → IDLE with `fault`=0 and `retry_cnt`=0.
- Enable drop: at 12'h840, set `en`=0.
  - Outputs step 12'h830 down to 12'h800 on successive ticks, then IDLE.
  - Raising `OVR_I_shtdwn` in the same cycle as the `en` drop → COOL, not a ramp-down.
- Reset mid-ramp: drop `rst_n` between clock edges at 12'h830 → outputs 12'h800 immediately, IDLE.
